sat_div_16: RTL and testbench
=============================

// Module: sat_div_16
// PURPOSE
//  Multi-cycle shift/subtract divider; inverse-direction companion of the saturating CLA add/sub unit.
//  Computes quotient and remainder of A/B, signed or unsigned, saturating on overflow.
//  Sits beside the ALU in EX; the pipeline stalls while busy is high.
//  Same flag semantics as the adder: ovfl marks a saturated result.
// PARAMETERS
//  WIDTH  16  operand, quotient and remainder width in bits (even, >=4)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  start      in   1      request; sampled only when busy=0
//  is_signed  in   1      1: two's-complement operands; 0: unsigned
//  A          in   WIDTH  dividend, captured on accepted start
//  B          in   WIDTH  divisor, captured on accepted start
//  busy       out  1      high from cycle after accept until done cycle (inclusive of FIX)
//  done       out  1      one-cycle pulse; quot/rem/flags valid from this cycle
//  quot       out  WIDTH  quotient, truncated toward zero
//  rem        out  WIDTH  remainder, sign follows dividend
//  ovfl       out  1      quotient not representable (signed MIN/-1)
//  dz         out  1      divisor was zero
// BEHAVIOUR
//  - Reset: state=IDLE; busy=0, done=0, quot=0, rem=0, ovfl=0, dz=0. Reset mid-operation aborts, no done.
//  - States: IDLE -> CALC (WIDTH cycles) -> FIX (1 cycle) -> IDLE. B==0 on accept: IDLE -> FIX directly.
//  - Accept at cycle T (start=1, state IDLE): latch |A|,|B| (raw if unsigned), sign(A), sign(A)^sign(B), is_signed.
//  - CALC: restoring step per cycle: {R,Q} shifted left; R-|B| via the internal WIDTH+1 subtractor; keep if non-negative, set Q[0].
//  - FIX: negate Q if quotient sign set, negate R if dividend negative; register outputs.
//  - done=1 at cycle T+WIDTH+2 (T+18 for WIDTH=16); divide-by-zero: done at T+2.
//  - busy=1 cycles T+1 .. T+WIDTH+1; busy=0 in the done cycle, so back-to-back start is accepted there.
//  - start while busy=1: ignored, operands not re-latched, no queueing.
//  - quot/rem/ovfl/dz hold their values until the next done or reset.
//  - Divide-by-zero: dz=1, rem=A; quot=0x7FFF if signed and A>=0, 0x8000 if signed and A<0, 0xFFFF if unsigned; ovfl=0.
//  - Signed MIN/-1 (0x8000/0xFFFF): ovfl=1, rem=0; quot per CONFIGURATION.
//  - Unsigned mode: ovfl never set. |MIN| is held in WIDTH+1 bits internally, no wrap.
//  - ovfl and dz are 0 on every normal completion.
// CONFIGURATION
//  DIV_SAT_EN defined: signed overflow saturates, quot=0x7FFF (MAX), matching adder saturation.
//  DIV_SAT_EN undefined: overflow wraps, quot=0x8000; ovfl still asserted.
//  Divide-by-zero results are identical in both builds.
// TESTING
//  1. signed 100/7 start at T -> done at T+18, quot=0x000E, rem=0x0002, ovfl=0, dz=0.
//  2. signed -100/7 (0xFF9C/0x0007) -> quot=0xFFF2, rem=0xFFFE; -100/-7 -> quot=0x000E, rem=0xFFFE.
//  3. signed 0x8000/0xFFFF -> ovfl=1, rem=0, quot=0x7FFF with DIV_SAT_EN, 0x8000 without.
//  4. signed 5/0 at T -> done at T+2, dz=1, quot=0x7FFF, rem=0x0005; unsigned 5/0 -> quot=0xFFFF.
//  5. unsigned 0xFFFF/0x0002 -> quot=0x7FFF, rem=0x0001; start pulsed at T+3 ignored, one done only.
//  6. rst=1 at T+5 of a divide -> next cycle busy=0, all outputs 0, no done; new start after rst completes normally.

Source files
------------

// File: rtl/sat_div_16.sv
// sat_div_16 -- multi-cycle restoring divider, signed/unsigned, saturating.
// Flow: IDLE -> CALC (WIDTH steps) -> FIX -> IDLE; a zero divisor skips CALC.
// Optional build macro: DIV_SAT_EN. When defined, the signed MIN/-1 quotient
// saturates to MAX. When undefined, it wraps to MIN. ovfl is raised either way.
module sat_div_16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             ovfl,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MAXP = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_q;      // dividend magnitude, shifted out as quotient bits shift in
  logic [WIDTH-1:0] r_r;      // partial remainder (always < divisor, so WIDTH bits suffice)
  logic [WIDTH:0]   r_d;      // divisor magnitude; WIDTH+1 bits so |MIN| never wraps
  logic             r_asign;  // dividend negative -> remainder negated
  logic             r_qsign;  // operand signs differ -> quotient negated
  logic             r_sgn;
  logic             r_zero;
  logic             r_busy, r_done, r_ovfl, r_dz;
  logic [WIDTH-1:0] r_quot, r_rem;

  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  logic [WIDTH:0]   w_rsh;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic             w_ov;

  // Magnitudes at accept; negating MIN yields 0x8000, which is correct as unsigned.
  assign w_a_mag = (is_signed && A[WIDTH-1]) ? -A : A;
  assign w_b_mag = (is_signed && B[WIDTH-1]) ? -B : B;

  // One restoring step: shift the next dividend bit into the remainder, then
  // trial-subtract. The compare is done on WIDTH+1 bits. The kept difference is
  // below the divisor, so only its low WIDTH bits are stored.
  assign w_rsh  = {r_r, r_q[WIDTH-1]};
  assign w_ge   = (w_rsh >= r_d);
  assign w_diff = w_rsh[WIDTH-1:0] - r_d[WIDTH-1:0];

  // Only signed MIN/-1 produces a positive magnitude with the top bit set.
  assign w_ov = r_sgn && !r_qsign && r_q[WIDTH-1];

  // Control FSM plus datapath; every output is registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_d     <= '0;
      r_asign <= 1'b0;
      r_qsign <= 1'b0;
      r_sgn   <= 1'b0;
      r_zero  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovfl  <= 1'b0;
      r_dz    <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_q     <= w_a_mag;
            r_r     <= '0;
            r_d     <= {1'b0, w_b_mag};
            r_asign <= is_signed & A[WIDTH-1];
            r_qsign <= is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
            r_sgn   <= is_signed;
            r_zero  <= (B == '0);
            r_cnt   <= CW'(WIDTH - 1);
            r_busy  <= 1'b1;
            r_state <= (B == '0) ? S_FIX : S_CALC;
          end
        end
        S_CALC: begin
          r_q <= {r_q[WIDTH-2:0], w_ge};
          r_r <= w_ge ? w_diff : w_rsh[WIDTH-1:0];
          if (r_cnt == '0) r_state <= S_FIX;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        S_FIX: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
          if (r_zero) begin
            // r_q still holds |A|; re-applying the sign gives back A.
            r_dz   <= 1'b1;
            r_ovfl <= 1'b0;
            r_quot <= r_sgn ? (r_asign ? MINN : MAXP) : {WIDTH{1'b1}};
            r_rem  <= r_asign ? -r_q : r_q;
          end else if (w_ov) begin
            r_dz   <= 1'b0;
            r_ovfl <= 1'b1;
`ifdef DIV_SAT_EN
            r_quot <= MAXP;
`else
            r_quot <= MINN;
`endif
            r_rem  <= '0;
          end else begin
            r_dz   <= 1'b0;
            r_ovfl <= 1'b0;
            r_quot <= r_qsign ? -r_q : r_q;
            r_rem  <= r_asign ? -r_r : r_r;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign quot = r_quot;
  assign rem  = r_rem;
  assign ovfl = r_ovfl;
  assign dz   = r_dz;

endmodule

// File: tb/tb_sat_div_16.sv
// Directed bench for sat_div_16 (WIDTH=16). Latency is counted in clock edges
// after the accept edge: 17 for a normal divide, 1 for a zero divisor.
module tb_sat_div_16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [15:0] A = '0, B = '0;
  logic        busy, done, ovfl, dz;
  logic [15:0] quot, rem;

  int passed = 0;
  int total  = 0;

  sat_div_16 #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .A(A), .B(B), .busy(busy), .done(done),
    .quot(quot), .rem(rem), .ovfl(ovfl), .dz(dz)
  );

  always #5 clk = ~clk;

`ifdef DIV_SAT_EN
  localparam logic [15:0] OVQ = 16'h7FFF;
`else
  localparam logic [15:0] OVQ = 16'h8000;
`endif

  // Launch one divide and wait (bounded) for done. lat=-1 means no done seen.
  // b1 = busy just after accept, b0 = busy in the done cycle.
  task automatic do_div(input logic s, input logic [15:0] a, input logic [15:0] b,
                        output int lat, output logic b1, output logic b0,
                        output logic [15:0] q, output logic [15:0] r,
                        output logic ov, output logic z);
    lat = -1; b0 = 1'b1; q = '0; r = '0; ov = 1'b0; z = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; is_signed = s; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0;
    b1 = busy;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n; b0 = busy; q = quot; r = rem; ov = ovfl; z = dz;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    total++;
    if ({busy, done, quot, rem, ovfl, dz} !== 36'h0) begin
      $display("FAIL reset: busy=%b done=%b quot=%h rem=%h ovfl=%b dz=%b, want all 0",
               busy, done, quot, rem, ovfl, dz);
    end else passed++;
  endtask

  // Directed vector table: sign mode, A, B, expected quot, rem, ovfl, dz, latency.
  task automatic test_vectors;
    logic        s  [11];
    logic [15:0] va [11], vb [11], eq [11], er [11];
    logic        eo [11], ez [11];
    int          el [11];
    int lat; logic b1, b0, ov, z; logic [15:0] q, r;
    s[0]=1; va[0]=16'd100;  vb[0]=16'd7;    eq[0]=16'h000E; er[0]=16'h0002; eo[0]=0; ez[0]=0; el[0]=17;
    s[1]=1; va[1]=16'hFF9C; vb[1]=16'h0007; eq[1]=16'hFFF2; er[1]=16'hFFFE; eo[1]=0; ez[1]=0; el[1]=17;
    s[2]=1; va[2]=16'hFF9C; vb[2]=16'hFFF9; eq[2]=16'h000E; er[2]=16'hFFFE; eo[2]=0; ez[2]=0; el[2]=17;
    s[3]=1; va[3]=16'h8000; vb[3]=16'hFFFF; eq[3]=OVQ;      er[3]=16'h0000; eo[3]=1; ez[3]=0; el[3]=17;
    s[4]=1; va[4]=16'd5;    vb[4]=16'd0;    eq[4]=16'h7FFF; er[4]=16'h0005; eo[4]=0; ez[4]=1; el[4]=1;
    s[5]=0; va[5]=16'd5;    vb[5]=16'd0;    eq[5]=16'hFFFF; er[5]=16'h0005; eo[5]=0; ez[5]=1; el[5]=1;
    s[6]=1; va[6]=16'hFFFB; vb[6]=16'd0;    eq[6]=16'h8000; er[6]=16'hFFFB; eo[6]=0; ez[6]=1; el[6]=1;
    s[7]=0; va[7]=16'h8000; vb[7]=16'hFFFF; eq[7]=16'h0000; er[7]=16'h8000; eo[7]=0; ez[7]=0; el[7]=17;
    s[8]=1; va[8]=16'h8000; vb[8]=16'h0001; eq[8]=16'h8000; er[8]=16'h0000; eo[8]=0; ez[8]=0; el[8]=17;
    s[9]=1; va[9]=16'd7;    vb[9]=16'hFFFE; eq[9]=16'hFFFD; er[9]=16'h0001; eo[9]=0; ez[9]=0; el[9]=17;
    s[10]=0; va[10]=16'hFFFF; vb[10]=16'h0003; eq[10]=16'h5555; er[10]=16'h0000; eo[10]=0; ez[10]=0; el[10]=17;
    for (int i = 0; i < 11; i++) begin
      do_div(s[i], va[i], vb[i], lat, b1, b0, q, r, ov, z);
      total++;
      if (lat !== el[i] || b1 !== 1'b1 || b0 !== 1'b0) begin
        $display("FAIL vec%0d_timing: lat=%0d busy_after_accept=%b busy_at_done=%b, want lat=%0d 1 0",
                 i, lat, b1, b0, el[i]);
      end else passed++;
      total++;
      if ({q, r, ov, z} !== {eq[i], er[i], eo[i], ez[i]}) begin
        $display("FAIL vec%0d_result: quot=%h rem=%h ovfl=%b dz=%b, want %h %h %b %b",
                 i, q, r, ov, z, eq[i], er[i], eo[i], ez[i]);
      end else passed++;
    end
  endtask

  // Unsigned 0xFFFF/2 with a stray start at T+3 (must be ignored, one done only).
  task automatic test_start_while_busy;
    int ndone = 0; int lat = -1; logic [15:0] q = '0, r = '0;
    @(posedge clk); #1;
    start = 1'b1; is_signed = 1'b0; A = 16'hFFFF; B = 16'h0002;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (n == 2) begin start = 1'b1; is_signed = 1'b1; A = 16'h0009; B = 16'h0003; end
      if (n == 3) start = 1'b0;
      if (done) begin
        ndone++;
        if (ndone == 1) begin lat = n; q = quot; r = rem; end
      end
    end
    total++;
    if (ndone !== 1 || lat !== 17) begin
      $display("FAIL busy_start_ignored: dones=%0d lat=%0d, want 1 and 17", ndone, lat);
    end else passed++;
    total++;
    if ({q, r} !== {16'h7FFF, 16'h0001}) begin
      $display("FAIL busy_start_result: quot=%h rem=%h, want 7fff 0001", q, r);
    end else passed++;
  endtask

  // Start asserted in the done cycle is accepted immediately.
  task automatic test_back_to_back;
    int lat = -1; logic bb;
    logic [15:0] q = '0, r = '0;
    int lat0; logic b1, b0, ov, z; logic [15:0] q0, r0;
    do_div(1'b0, 16'd1000, 16'd10, lat0, b1, b0, q0, r0, ov, z);
    start = 1'b1; is_signed = 1'b1; A = 16'hFFF6; B = 16'h0003;
    @(posedge clk); #1;
    start = 1'b0;
    bb = busy;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done) begin lat = n; q = quot; r = rem; break; end
    end
    total++;
    if (lat0 !== 17 || q0 !== 16'd100 || r0 !== 16'd0) begin
      $display("FAIL b2b_first: lat=%0d quot=%h rem=%h, want 17 0064 0000", lat0, q0, r0);
    end else passed++;
    total++;
    if (bb !== 1'b1 || lat !== 17 || q !== 16'hFFFD || r !== 16'hFFFF) begin
      $display("FAIL b2b_second: busy=%b lat=%0d quot=%h rem=%h, want 1 17 fffd ffff", bb, lat, q, r);
    end else passed++;
  endtask

  // Reset at T+5 aborts the divide; a following divide works normally.
  task automatic test_reset_abort;
    int ndone = 0;
    int lat; logic b1, b0, ov, z; logic [15:0] q, r;
    @(posedge clk); #1;
    start = 1'b1; is_signed = 1'b1; A = 16'd200; B = 16'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if ({busy, done, quot, rem, ovfl, dz} !== 36'h0) begin
      $display("FAIL reset_abort_state: busy=%b done=%b quot=%h rem=%h ovfl=%b dz=%b, want all 0",
               busy, done, quot, rem, ovfl, dz);
    end else passed++;
    for (int n = 0; n < 25; n++) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    total++;
    if (ndone !== 0) begin
      $display("FAIL reset_abort_quiet: %0d cycles with done/busy, want 0", ndone);
    end else passed++;
    do_div(1'b1, 16'd200, 16'd9, lat, b1, b0, q, r, ov, z);
    total++;
    if (lat !== 17 || {q, r, ov, z} !== {16'd22, 16'd2, 1'b0, 1'b0}) begin
      $display("FAIL reset_recover: lat=%0d quot=%h rem=%h ovfl=%b dz=%b, want 17 0016 0002 0 0",
               lat, q, r, ov, z);
    end else passed++;
  endtask

  initial begin
    test_reset;
    test_vectors;
    test_start_while_busy;
    test_back_to_back;
    test_reset_abort;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
